mux_rr_n: RTL and testbench

Parametrised N-channel, W-bit valid/data multiplexer with per-channel input FIFOs and a registered output that honours downstream backpressure. It supersedes the fixed two-channel, 8-bit mux in the Project 1 datapath. It merges several producer streams onto one output bus, tagging each word with its source channel. Arbitration is round-robin, so no channel starves while others stay busy.

---
 rtl/mux_rr_pkg.sv | 14 +
 rtl/mux_rr_fifo.sv | 74 +++++++
 rtl/mux_rr_n.sv | 146 ++++++++++++++
 tb/tb_mux_rr_n.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// Shared definitions for the N-channel round-robin mux.
// Holds the default WIDTH/CHANNELS/DEPTH values and chan_w(), which gives the
// width of a channel index: max(1, $clog2(n)).
package mux_rr_pkg;

    localparam int unsigned DefaultWidth    = 8;
    localparam int unsigned DefaultChannels = 2;
    localparam int unsigned DefaultDepth    = 4;

    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_fifo.sv
// Single-clock FIFO used as the per-channel input buffer of mux_rr_n.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, wdata_i     write strobe and word (ignored while full)
//   pop_i               read strobe (ignored while empty)
//   head_o              word at the read pointer
//   full_o, empty_o     registered status flags
//   count_o             number of stored words
// DEPTH must be a power of two so the pointers wrap naturally.
module mux_rr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             push_en, pop_en;

    // Full is taken from the registered flag, so a write to a full FIFO is
    // dropped even when the same cycle pops it.
    assign push_en = push_i & ~full_q;
    assign pop_en  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FullCount);
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/mux_rr_n.sv
// N-channel, W-bit valid/data multiplexer with per-channel input FIFOs and a
// registered output stage that honours downstream backpressure. Each output
// word is tagged with its source channel.
// Ports:
//   clk, reset (async, active-low)
//   data_in/valid_in    per-channel words and write strobes
//   full_out            per-channel FIFO full (registered)
//   overflow_out        sticky: a write hit a full FIFO
//   ready_in            downstream accepts data_out this cycle
//   data_out/chan_out   registered word and its source channel
//   valid_out           data_out/chan_out hold a word
// Configuration macro MUX_RR_FIXED_PRIO_EN: when defined the lowest-index
// non-empty channel always wins and no last-grant state exists; otherwise
// arbitration is round-robin starting after the last granted channel.
module mux_rr_n
    import mux_rr_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned CHANNELS = DefaultChannels,
    parameter int unsigned DEPTH    = DefaultDepth
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS*WIDTH-1:0]     data_in,
    input  logic [CHANNELS-1:0]           valid_in,
    output logic [CHANNELS-1:0]           full_out,
    output logic [CHANNELS-1:0]           overflow_out,
    input  logic                          ready_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [chan_w(CHANNELS)-1:0]   chan_out,
    output logic                          valid_out
);

    localparam int unsigned ChanW = chan_w(CHANNELS);
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]    head [CHANNELS];
    logic [CntW-1:0]     fifo_count [CHANNELS];
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] pop;

    logic [WIDTH-1:0]    data_q;
    logic [ChanW-1:0]    chan_q;
    logic                valid_q;
    logic [CHANNELS-1:0] overflow_q;
`ifndef MUX_RR_FIXED_PRIO_EN
    logic [ChanW-1:0]    last_grant_q;
`endif

    logic                load;
    logic                grant_valid;
    logic [ChanW-1:0]    grant;
    logic                unused_fifo_count;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_fifo
        mux_rr_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk_i  (clk),
            .rst_ni (reset),
            .push_i (valid_in[i]),
            .wdata_i(data_in[i*WIDTH +: WIDTH]),
            .pop_i  (pop[i]),
            .head_o (head[i]),
            .full_o (full_out[i]),
            .empty_o(empty[i]),
            .count_o(fifo_count[i])
        );
    end

    // Occupancy is tracked inside each FIFO; the arbiter only needs empty.
    always_comb begin
        unused_fifo_count = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            unused_fifo_count = unused_fifo_count ^ (^fifo_count[i]);
        end
    end

    // Output register can take a new word when empty or being drained.
    assign load = ~valid_q | ready_in;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
`ifdef MUX_RR_FIXED_PRIO_EN
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!grant_valid && !empty[ChanW'(k)]) begin
                grant_valid = 1'b1;
                grant       = ChanW'(k);
            end
        end
`else
        // Scan last_grant+1, last_grant+2, ... wrapping, so last_grant is
        // visited last and every busy channel gets a turn.
        for (int unsigned k = 1; k <= CHANNELS; k++) begin : scan
            int unsigned idx;
            idx = (32'(last_grant_q) + k) % CHANNELS;
            if (!grant_valid && !empty[ChanW'(idx)]) begin
                grant_valid = 1'b1;
                grant       = ChanW'(idx);
            end
        end
`endif
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pop[i] = load & grant_valid & (grant == ChanW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q       <= '0;
            chan_q       <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= '0;
`ifndef MUX_RR_FIXED_PRIO_EN
            last_grant_q <= ChanW'(CHANNELS - 1);
`endif
        end else begin
            overflow_q <= overflow_q | (valid_in & full_out);
            if (load) begin
                if (grant_valid) begin
                    data_q       <= head[grant];
                    chan_q       <= grant;
                    valid_q      <= 1'b1;
`ifndef MUX_RR_FIXED_PRIO_EN
                    last_grant_q <= grant;
`endif
                end else begin
                    // Nothing pending: drop valid, keep last word/channel.
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign data_out     = data_q;
    assign chan_out     = chan_q;
    assign valid_out    = valid_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n (WIDTH=8, CHANNELS=2, DEPTH=4).
// A queue-based reference model predicts every output word into a scoreboard
// and the per-cycle valid/full/overflow state; a monitor on the falling edge
// compares the DUT against it.
module tb_mux_rr_n;
    import mux_rr_pkg::*;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = chan_w(CHANNELS);

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [CHANNELS*WIDTH-1:0] data_in = '0;
    logic [CHANNELS-1:0]       valid_in = '0;
    logic [CHANNELS-1:0]       full_out;
    logic [CHANNELS-1:0]       overflow_out;
    logic                      ready_in = 1'b0;
    logic [WIDTH-1:0]          data_out;
    logic [CW-1:0]             chan_out;
    logic                      valid_out;

    mux_rr_n #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .full_out    (full_out),
        .overflow_out(overflow_out),
        .ready_in    (ready_in),
        .data_out    (data_out),
        .chan_out    (chan_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0]    mq [CHANNELS][$];
    logic [CW+WIDTH-1:0] exp_q [$];
    logic                m_valid = 1'b0;
    logic [CHANNELS-1:0] m_full = '0;
    logic [CHANNELS-1:0] m_ovf = '0;
    int                  m_last = CHANNELS - 1;

    always @(posedge clk or negedge reset) begin
        int               sz [CHANNELS];
        bit               found;
        int               g;
        int               c;
        logic [WIDTH-1:0] w;
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) mq[i].delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_full  = '0;
            m_ovf   = '0;
            m_last  = CHANNELS - 1;
        end else begin
            // Occupancy before this edge decides whether a write fits.
            for (int i = 0; i < CHANNELS; i++) sz[i] = mq[i].size();
            if (!m_valid || ready_in) begin
                found = 1'b0;
                g     = 0;
                for (int k = 0; k < CHANNELS; k++) begin
`ifdef MUX_RR_FIXED_PRIO_EN
                    c = k;
`else
                    c = (m_last + 1 + k) % CHANNELS;
`endif
                    if (!found && sz[c] != 0) begin
                        found = 1'b1;
                        g     = c;
                    end
                end
                if (found) begin
                    w = mq[g].pop_front();
                    exp_q.push_back({CW'(g), w});
                    m_valid = 1'b1;
                    m_last  = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (valid_in[i]) begin
                    if (sz[i] < DEPTH) mq[i].push_back(data_in[i*WIDTH +: WIDTH]);
                    else m_ovf[i] = 1'b1;
                end
            end
            for (int i = 0; i < CHANNELS; i++) m_full[i] = (mq[i].size() == DEPTH);
        end
    end

    // ---------------- monitor ----------------
    logic [CW+WIDTH-1:0] e;

    always @(negedge clk) begin
        if (reset) begin
            check("valid_out", 32'(valid_out), 32'(m_valid));
            check("full_out", 32'(full_out), 32'(m_full));
            check("overflow_out", 32'(overflow_out), 32'(m_ovf));
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(e[WIDTH-1:0]));
                    check("chan_out", 32'(chan_out), 32'(e[CW+WIDTH-1:WIDTH]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [CHANNELS-1:0] v, input logic [CHANNELS*WIDTH-1:0] d,
                         input logic r);
        @(posedge clk);
        #2;
        valid_in = v;
        data_in  = d;
        ready_in = r;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        valid_in = '0;
        reset    = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_chan_out", 32'(chan_out), 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_full_out", 32'(full_out), 32'h0);
        check("rst_overflow_out", 32'(overflow_out), 32'h0);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        ready_in = 1'b1;

        // Two-edge latency from input sample to valid_out
        drive(2'b01, 16'h005A, 1'b1);
        drive(2'b00, 16'h0000, 1'b1);
        @(negedge clk);
        check("lat_valid_after_1_edge", 32'(valid_out), 32'h0);
        @(negedge clk);
        check("lat_valid_after_2_edges", 32'(valid_out), 32'h1);
        check("lat_data", 32'(data_out), 32'h5A);
        check("lat_chan", 32'(chan_out), 32'h0);

        // Alternation, then an asynchronous reset while a word is presented
        pulse_reset();
        for (int j = 0; j < 6; j++) begin
            drive(2'b11, {8'(8'hFF - j), 8'(8'h11 + j)}, 1'b1);
        end
        @(posedge clk);
        #3;
        check("pre_reset_valid", 32'(valid_out), 32'h1);
        reset = 1'b0;
        #1;
        check("async_rst_data_out", 32'(data_out), 32'h0);
        check("async_rst_chan_out", 32'(chan_out), 32'h0);
        check("async_rst_valid_out", 32'(valid_out), 32'h0);
        check("async_rst_full_out", 32'(full_out), 32'h0);
        valid_in = '0;
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Single channel, back to back
        drive(2'b10, 16'hA500, 1'b1);
        drive(2'b10, 16'hA600, 1'b1);
        repeat (4) drive(2'b00, 16'h0000, 1'b1);

        // Backpressure and overflow on ch0
        for (int j = 1; j <= 6; j++) drive(2'b01, 16'(j), 1'b0);
        drive(2'b00, 16'h0000, 1'b0);
        @(negedge clk);
        check("bp_data_held", 32'(data_out), 32'h01);
        check("bp_full0", 32'(full_out[0]), 32'h1);
        check("bp_overflow0", 32'(overflow_out[0]), 32'h1);
        repeat (8) drive(2'b00, 16'h0000, 1'b1);
        check("bp_overflow0_sticky", 32'(overflow_out[0]), 32'h1);

        // Pointer wrap on ch0
        for (int j = 0; j < 10; j++) drive(2'b01, 16'(8'h30 + j), 1'b1);
        repeat (4) drive(2'b00, 16'h0000, 1'b1);

        // Randomised traffic with stall bursts
        pulse_reset();
        for (int c = 0; c < 1500; c++) begin
            logic r;
            r = ((c / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            drive(CHANNELS'($urandom_range(0, 3)), 16'($urandom), r);
        end

        // Drain, bounded
        drive(2'b00, 16'h0000, 1'b1);
        for (int t = 0; t < 40 && (exp_q.size() != 0 || valid_out); t++) @(negedge clk);
        check("drain_pending_words", 32'(exp_q.size()), 32'h0);
        check("drain_valid_out", 32'(valid_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
